// File: rtl/fp_to_int.sv
// IEEE 754 single-precision to signed 32-bit integer converter, truncating toward zero.
// Iterative: one bit of alignment shift per cycle, valid/ready on both sides.
module fp_to_int (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_invalid,
   output logic        out_inexact
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic        sign_q, sign_d;
   logic [31:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        left_q, left_d;
   logic        inexact_q, inexact_d;
   logic        invalid_q, invalid_d;
   logic        special_q, special_d;
   logic        sat_pos_q, sat_pos_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_invalid_q, out_invalid_d;
   logic        out_inexact_q, out_inexact_d;

   logic [7:0]  exp_f;
   logic [22:0] frac_f;
   logic [31:0] mant;

   assign exp_f  = in_data[30:23];
   assign frac_f = in_data[22:0];
   assign mant   = {8'd0, 1'b1, frac_f};

   always_comb begin
      state_d       = state_q;
      sign_d        = sign_q;
      mag_d         = mag_q;
      cnt_d         = cnt_q;
      left_d        = left_q;
      inexact_d     = inexact_q;
      invalid_d     = invalid_q;
      special_d     = special_q;
      sat_pos_d     = sat_pos_q;
      out_data_d    = out_data_q;
      out_invalid_d = out_invalid_q;
      out_inexact_d = out_inexact_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d   = StShift;
               sign_d    = in_data[31];
               mag_d     = 32'd0;
               cnt_d     = 5'd0;
               left_d    = 1'b0;
               inexact_d = 1'b0;
               invalid_d = 1'b0;
               special_d = 1'b0;
               sat_pos_d = 1'b0;
               if (exp_f == 8'd255) begin
                  // NaN always maps to the negative limit; infinity saturates by sign
                  special_d = 1'b1;
                  invalid_d = 1'b1;
                  sat_pos_d = (frac_f == 23'd0) && !in_data[31];
               end else if (exp_f >= 8'd158) begin
                  special_d = 1'b1;
                  invalid_d = (in_data != 32'hCF00_0000);
                  sat_pos_d = !in_data[31];
               end else if (exp_f >= 8'd150) begin
                  mag_d  = mant;
                  left_d = 1'b1;
                  cnt_d  = 5'(exp_f - 8'd150);
               end else if (exp_f >= 8'd127) begin
                  mag_d = mant;
                  cnt_d = 5'(8'd150 - exp_f);
               end else begin
                  inexact_d = (exp_f != 8'd0) || (frac_f != 23'd0);
               end
            end
         end
         StShift: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
               if (left_q) begin
                  mag_d = {mag_q[30:0], 1'b0};
               end else begin
                  mag_d     = {1'b0, mag_q[31:1]};
                  inexact_d = inexact_q | mag_q[0];
               end
            end else begin
               if (special_q) begin
                  out_data_d = sat_pos_q ? 32'h7FFF_FFFF : 32'h8000_0000;
               end else begin
                  out_data_d = sign_q ? (32'd0 - mag_q) : mag_q;
               end
               out_invalid_d = invalid_q;
               out_inexact_d = inexact_q;
               state_d       = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         sign_q        <= 1'b0;
         mag_q         <= 32'd0;
         cnt_q         <= 5'd0;
         left_q        <= 1'b0;
         inexact_q     <= 1'b0;
         invalid_q     <= 1'b0;
         special_q     <= 1'b0;
         sat_pos_q     <= 1'b0;
         out_data_q    <= 32'd0;
         out_invalid_q <= 1'b0;
         out_inexact_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sign_q        <= sign_d;
         mag_q         <= mag_d;
         cnt_q         <= cnt_d;
         left_q        <= left_d;
         inexact_q     <= inexact_d;
         invalid_q     <= invalid_d;
         special_q     <= special_d;
         sat_pos_q     <= sat_pos_d;
         out_data_q    <= out_data_d;
         out_invalid_q <= out_invalid_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = (state_q == StDone);
   assign out_data    = out_data_q;
   assign out_invalid = out_invalid_q;
   assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboarded random/directed bench for fp_to_int against an arithmetic reference model.
module tb_fp_to_int;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_invalid;
   logic        out_inexact;

   fp_to_int dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_invalid (out_invalid),
      .out_inexact (out_inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        inv;
      logic        inx;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   ep = 0;
   bit   stall_once = 0;
   bit   rand_ready = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Value semantics: truncate m*2^(e-23) toward zero, then range-check as a signed integer.
   function automatic exp_t model(input logic [31:0] f);
      exp_t   r;
      int     ex, e;
      longint m, mag, v;
      r.data = 32'd0; r.inv = 1'b0; r.inx = 1'b0; r.lat = 2; r.acc = 0;
      ex = int'(f[30:23]);
      e  = ex - 127;
      if (ex == 255) begin
         r.inv  = 1'b1;
         r.data = (f[22:0] != 0 || f[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else if (ex == 0 || e < 0) begin
         r.inx = (ex != 0) || (f[22:0] != 0);
      end else if (e >= 40) begin
         r.inv  = 1'b1;
         r.data = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         m = longint'({1'b1, f[22:0]});
         if (e >= 23) begin
            mag = m << (e - 23);
            r.lat = (e >= 31) ? 2 : e - 23 + 2;
         end else begin
            mag   = m >> (23 - e);
            r.inx = (m % (64'sd1 << (23 - e))) != 0;
            r.lat = 23 - e + 2;
         end
         v = f[31] ? -mag : mag;
         if (v > 64'sd2147483647) begin
            r.inv = 1'b1; r.data = 32'h7FFF_FFFF;
         end else if (v < -64'sd2147483648) begin
            r.inv = 1'b1; r.data = 32'h8000_0000;
         end else begin
            r.data = v[31:0];
         end
      end
      return r;
   endfunction

   task automatic send(input logic [31:0] d);
      exp_t e;
      int   t;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 200) begin
            chk("accept_timeout", 32'(t), 32'd0);
            break;
         end
      end
      e     = model(d);
      e.acc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic gap(input int k);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      repeat (k) @(posedge clk);
   endtask

   // Output consumer
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (out_valid && stall_once) begin
            stall_once = 0;
            out_ready  = 1'b0;
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
         end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   // Monitor
   initial begin
      exp_t        e;
      logic [33:0] held;
      bit          released = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ep = 0; released = 0;
         end else if (out_valid) begin
            if (!ep) begin
               ep = 1;
               if (exp_q.size() == 0) begin
                  chk("unexpected_out_valid", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e.data);
                  chk("out_invalid", 32'(out_invalid), 32'(e.inv));
                  chk("out_inexact", 32'(out_inexact), 32'(e.inx));
                  chk("latency", 32'(cyc - e.acc), 32'(e.lat));
               end
               held = {out_data, out_invalid, out_inexact};
            end else begin
               chk("done_stable", {out_data, out_invalid, out_inexact}, held);
            end
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) begin
               ep = 0; released = 1;
            end
         end else if (released) begin
            released = 0;
            chk("in_ready_after_release", 32'(in_ready), 32'd1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   logic [31:0] dir_vec [10] = '{32'h4049_0FDB, 32'hC2F6_0000, 32'h4EFF_FFFF, 32'h4F00_0000,
                                 32'hCF00_0000, 32'h7FC0_0000, 32'h3F00_0000, 32'h0000_0001,
                                 32'h8000_0000, 32'hFF80_0000};

   initial begin
      logic [31:0] d;
      int          t;
      rst = 1'b1; in_valid = 1'b1; in_data = 32'h3F80_0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_priority_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_invalid", 32'(out_invalid), 32'd0);
      chk("rst_out_inexact", 32'(out_inexact), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      repeat (2) @(posedge clk);

      stall_once = 1;
      foreach (dir_vec[i]) send(dir_vec[i]);
      gap(3);

      // Back-to-back with in_valid held high
      for (int i = 0; i < 6; i++) send(32'h4000_0000 + (i << 20));
      gap(2);

      // Reset during SHIFT discards the operand
      send(32'h4049_0FDB);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      chk("midrst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
      repeat (30) @(posedge clk);

      rand_ready = 1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: d = $urandom;
            1: d = {1'($urandom), 8'($urandom_range(118, 162)), 23'($urandom)};
            2: d = {1'($urandom), 8'($urandom_range(150, 158)), 23'($urandom_range(0, 3))};
            default: d = {1'($urandom), 8'($urandom_range(126, 140)), 23'($urandom)};
         endcase
         send(d);
         if ($urandom_range(0, 4) == 0) gap($urandom_range(0, 3));
      end
      gap(1);

      t = 0;
      while ((exp_q.size() != 0 || ep) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 32'(exp_q.size() != 0 || ep), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  in_data holds an operand.
REQ-004 SHALL have: in_ready  output  1  block can accept an operand.
REQ-005 SHALL have: in_data  input  32  IEEE 754 single-precision operand.
REQ-006 SHALL have: out_valid  output  1  out_data and flags hold a result.
REQ-007 SHALL have: out_ready  input  1  consumer takes the result.
REQ-008 SHALL have: out_data  output  32  signed two's-complement integer result.
REQ-009 SHALL have: out_invalid  output  1  NaN, infinity or out-of-range input.
REQ-010 SHALL have: out_inexact  output  1  nonzero fraction bits discarded.

Function
REQ-011 SHALL convert float to signed 32-bit integer, rounding toward zero.
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL accept an operand on the edge where in_valid && in_ready, then move IDLE->SHIFT, latching sign, a 32-bit magnitude register, a 5-bit count n, a direction bit and the class flags.
REQ-014 SHALL decode the operand as e = exp-127 and mantissa m = {1, frac}; exp==0 (zero or subnormal) SHALL be treated as e<0.
REQ-015 SHALL load, when 0<=e<=22: magnitude = m, direction right, n = 23-e (1..23).
REQ-016 SHALL load, when 23<=e<=30: magnitude = m, direction left, n = e-23 (0..7).
REQ-017 SHALL load, when e<0: magnitude = 0, n = 0, inexact = (exp!=0 || frac!=0).
REQ-018 SHALL load, for NaN (exp==255, frac!=0): n = 0, result 0x80000000, invalid = 1.
REQ-019 SHALL load, for e>=31 or infinity: n = 0, invalid = 1, result 0x7FFFFFFF if sign==0 and 0x80000000 if sign==1.
REQ-020 SHALL treat exactly -2^31 (0xCF000000) as exact: result 0x80000000, invalid = 0.
REQ-021 SHALL, in SHIFT with n!=0, shift the magnitude one bit per cycle in the latched direction and decrement n.
REQ-022 SHALL, on a right shift, OR every bit shifted out into a sticky inexact flag.
REQ-023 SHALL, in SHIFT with n==0, register out_data (negated magnitude if sign==1, override value if a special case applies) and the flags, then go to DONE.
REQ-024 SHALL assert out_valid exactly n+2 cycles after the accept edge (latency 2..25 cycles).
REQ-025 SHALL hold out_data, out_invalid, out_inexact and out_valid stable in DONE while out_ready==0.
REQ-026 SHALL return to IDLE on the edge where out_valid && out_ready; in_ready rises the following cycle, with no same-cycle accept while in DONE.
REQ-027 SHALL ignore in_data and in_valid outside IDLE.
REQ-028 SHALL produce negative zero (0x80000000 input) as 0x00000000 with no flags set.

Reset
REQ-029 SHALL, on rst==1 at a clock edge, enter IDLE regardless of state, including mid-SHIFT or held DONE; the in-flight operand SHALL be discarded.
REQ-030 SHALL reset outputs to in_ready=1, out_valid=0, out_data=0, out_invalid=0, out_inexact=0; internal magnitude, count and flags SHALL clear to 0.
REQ-031 SHALL give rst priority over any in_valid/out_ready handshake in the same cycle.

Verification
REQ-032 SHALL cover: in 0x40490FDB (3.14159) -> out 0x00000003, inexact=1, invalid=0, out_valid 24 cycles after accept.
REQ-033 SHALL cover: in 0xC2F60000 (-123.0) -> out 0xFFFFFF85, no flags, latency 19; in 0x4EFFFFFF -> 0x7FFFFF80, no flags, latency 9.
REQ-034 SHALL cover: in 0x4F000000 -> 0x7FFFFFFF, invalid=1; in 0xCF000000 -> 0x80000000, invalid=0; in 0x7FC00000 -> 0x80000000, invalid=1; each with latency 2.
REQ-035 SHALL cover: in 0x3F000000 (0.5) -> 0, inexact=1; in 0x00000001 -> 0, inexact=1; in 0x80000000 -> 0, no flags.
REQ-036 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle; back-to-back operands with in_valid held high are each accepted once.
REQ-037 SHALL cover: rst pulsed during SHIFT of 0x40490FDB -> IDLE and reset output values next cycle, no out_valid for that operand.
